pwm: RTL and testbench



---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm.sv | 61 ++++++
 tb/tb_pwm.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the single-channel PWM block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_pkg;

   // Ticks per PWM period; also the duty value that means 100 %.
   localparam int PWM_PERIOD_TICKS = 100;
   // Width of duty command and internal counters (2**PWM_DUTY_W > PWM_PERIOD_TICKS).
   localparam int PWM_DUTY_W       = 7;

   typedef logic [PWM_DUTY_W-1:0] duty_t;

endpackage : pwm_pkg

// File: rtl/pwm.sv
// Single-channel PWM: fixed period of PERIOD_TICKS enable ticks, high time = latched duty.
// Latency: out is registered and lags the tick counter by one clk cycle.
// Backpressure: none; one_MHz_enable low freezes counter and duty, out holds its level.
//
// Ports:
//   clk            - system clock, all state changes on the rising edge
//   reset          - asynchronous active-low reset (0 = reset asserted)
//   one_MHz_enable - single-clk tick strobe, advances the period counter
//   duty_cycle     - requested duty in ticks (percent at 100 ticks); saturates at PERIOD_TICKS
//   out            - registered PWM waveform
module pwm
   import pwm_pkg::*;
#(
   parameter int PERIOD_TICKS = PWM_PERIOD_TICKS,
   parameter int DUTY_W       = PWM_DUTY_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              one_MHz_enable,
   input  logic [DUTY_W-1:0] duty_cycle,
   output logic              out
);

   localparam logic [DUTY_W-1:0] LP_PERIOD = DUTY_W'(PERIOD_TICKS);
   localparam logic [DUTY_W-1:0] LP_LAST   = DUTY_W'(PERIOD_TICKS - 1);

   // Clamp a duty command to the full-period value.
   function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] i_duty);
      return (i_duty > LP_PERIOD) ? LP_PERIOD : i_duty;
   endfunction

   logic [DUTY_W-1:0] r_cnt;
   logic [DUTY_W-1:0] r_duty_q;
   logic              r_out;
   logic              w_wrap;

   assign w_wrap = (r_cnt == LP_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_duty_q <= '0;
         r_out    <= 1'b0;
      end else begin
         if (one_MHz_enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + DUTY_W'(1);
            // Duty only changes at the period boundary so a mid-period
            // command never truncates or stretches the current pulse.
            if (w_wrap) begin
               r_duty_q <= sat_duty(duty_cycle);
            end
         end
         // Full duty (r_duty_q == PERIOD_TICKS) is above every counter
         // value, so the output stays high across the wrap.
         r_out <= (r_cnt < r_duty_q);
      end
   end

   assign out = r_out;

endmodule : pwm

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: directed duty programs, expected level per tick queued by stimulus.
// Latency: each tick's expected level is compared two clk edges after the tick is sampled.
// Backpressure: n/a; the monitor pops one expectation per observed tick.
module tb_pwm;

   logic       clk;
   logic       reset;
   logic       one_MHz_enable;
   logic [6:0] duty_cycle;
   logic       out;

   pwm #(
      .PERIOD_TICKS(100),
      .DUTY_W      (7)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .one_MHz_enable(one_MHz_enable),
      .duty_cycle    (duty_cycle),
      .out           (out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int   idx;
      logic v;
   } exp_t;

   exp_t exp_q[$];

   int   n_tests  = 0;
   int   n_fail   = 0;
   int   j        = 0;   // ticks since reset release
   int   exp_cur  = 0;   // hand-set high count of the running period
   int   exp_next = 0;   // hand-set high count for the period after the next wrap
   logic chk_const = 1'b0;
   logic chk_val   = 1'b0;
   logic en_d1     = 1'b0;
   logic en_d2     = 1'b0;

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: out=%0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one enable tick and queue the level out must show for the new count.
   // Called and returns at posedge+1.
   task automatic tick(input int gap);
      int   c;
      exp_t e;
      one_MHz_enable = 1'b1;
      @(posedge clk); #1;
      one_MHz_enable = 1'b0;
      j++;
      c = j % 100;
      if (c == 0) exp_cur = exp_next;
      e.idx = j;
      e.v   = (c < exp_cur);
      exp_q.push_back(e);
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_ticks(input int n, input int gap);
      for (int k = 0; k < n; k++) tick(gap);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Tick delay line: out reflects a tick's new count after the following edge.
   always @(posedge clk) begin
      en_d1 <= one_MHz_enable;
      en_d2 <= en_d1;
   end

   // Monitor: consumes one expectation per observed tick, plus steady-level checks.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (en_d2) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tick_underflow: out=%0b sampled with no expected value", out);
            end else begin
               e = exp_q.pop_front();
               check_bit($sformatf("tick_%0d", e.idx), out, e.v);
            end
         end
         if (chk_const) check_bit("steady_level", out, chk_val);
      end
   end

   initial begin
      reset          = 1'b0;
      one_MHz_enable = 1'b0;
      duty_cycle     = 7'd0;

      // Reset state
      cycles(3);
      check_bit("reset_out", out, 1'b0);
      reset = 1'b1;

      // Duty 0, slow ticks: constant low
      duty_cycle = 7'd0;
      exp_next   = 0;
      chk_val    = 1'b0;
      chk_const  = 1'b1;
      run_ticks(300, 99);
      chk_const  = 1'b0;

      // Duty 50: low period already running, then 50/50
      duty_cycle = 7'd50;
      exp_next   = 50;
      run_ticks(300, 3);

      // Full duty then saturated duty: constant high after the boundary
      duty_cycle = 7'd100;
      exp_next   = 100;
      run_ticks(100, 3);
      chk_val    = 1'b1;
      chk_const  = 1'b1;
      duty_cycle = 7'd127;
      exp_next   = 100;
      run_ticks(100, 0);   // back-to-back ticks
      run_ticks(100, 3);
      chk_const  = 1'b0;

      // Mid-period change: 25 -> 75 at tick 10
      duty_cycle = 7'd25;
      exp_next   = 25;
      run_ticks(100, 3);
      run_ticks(10, 3);
      duty_cycle = 7'd75;
      exp_next   = 75;
      run_ticks(90, 3);
      run_ticks(100, 3);

      // Asynchronous reset while out is high
      run_ticks(20, 3);
      cycles(3);
      check_bit("pre_reset_high", out, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check_bit("async_reset_out", out, 1'b0);
      cycles(2);
      check_bit("reset_hold_out", out, 1'b0);
      reset    = 1'b1;
      j        = 0;
      exp_cur  = 0;
      exp_next = 75;
      run_ticks(200, 3);

      // Enable gating mid-high-phase
      duty_cycle = 7'd50;
      exp_next   = 50;
      run_ticks(100, 3);
      run_ticks(20, 3);
      check_bit("gate_start_high", out, 1'b1);
      chk_val    = 1'b1;
      chk_const  = 1'b1;
      cycles(500);
      chk_const  = 1'b0;
      check_bit("gate_end_high", out, 1'b1);
      run_ticks(180, 3);

      cycles(5);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pwm
